// File: rtl/aes_key_sequencer.sv
// AES-256 key-schedule sequencer: steps the datapath through rounds 0..NUM_ROUNDS,
// captures each round key into a local buffer and serves indexed reads that
// stall until the requested key has been captured.
module aes_key_sequencer #(
  parameter int unsigned NUM_ROUNDS     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned TW             = 6
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [255:0] key_i,
  output logic [255:0] ks_key_o,
  output logic         ks_en_o,
  output logic [3:0]   ks_round_o,
  input  logic         ks_ready_i,
  input  logic [127:0] ks_key_i,
  input  logic         rk_req_i,
  input  logic [3:0]   rk_idx_i,
  output logic         rk_valid_o,
  output logic [127:0] rk_key_o,
  output logic         rk_oor_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [TW-1:0]       r_to;
  logic [NUM_ROUNDS:0] r_mask;
  logic [255:0]        r_ks_key;
  logic                r_ks_en;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [127:0]        r_buf [0:NUM_ROUNDS];
  logic                r_rk_valid;
  logic                r_rk_oor;
  logic [127:0]        r_rk_key;

  logic w_wr_en;
  logic w_oor;
  logic w_hit;
  logic w_avail;

  // A capture is suppressed when start_i restarts the sequence in the same cycle
  assign w_wr_en = (r_state == S_CAPTURE) && !start_i;
  assign w_oor   = 32'(rk_idx_i) > NUM_ROUNDS;
  assign w_hit   = w_wr_en && (rk_idx_i == r_cnt);
  assign w_avail = !start_i && r_mask[rk_idx_i];

  // Sequencing FSM with registered datapath handshake and status outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_to     <= '0;
      r_mask   <= '0;
      r_ks_key <= '0;
      r_ks_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else if (start_i) begin
      r_state  <= S_ISSUE;
      r_cnt    <= 4'd0;
      r_to     <= '0;
      r_mask   <= '0;
      r_ks_key <= key_i;
      r_ks_en  <= 1'b1;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (ks_ready_i) begin
            r_state <= S_CAPTURE;
            r_ks_en <= 1'b0;
          end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state <= S_ERROR;
            r_ks_en <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        S_CAPTURE: begin
          r_mask[r_cnt] <= 1'b1;
          if (r_cnt == 4'(NUM_ROUNDS)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_ISSUE;
            r_cnt   <= r_cnt + 4'd1;
            r_to    <= '0;
            r_ks_en <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-key storage; contents are only meaningful where the mask bit is set
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_buf[r_cnt] <= ks_key_i;
    end
  end

  // Read port: one pulse per served request, same-cycle capture bypasses the buffer
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rk_valid <= 1'b0;
      r_rk_oor   <= 1'b0;
      r_rk_key   <= '0;
    end else begin
      r_rk_valid <= 1'b0;
      r_rk_oor   <= 1'b0;
      if (rk_req_i && !r_rk_valid) begin
        if (w_oor) begin
          r_rk_valid <= 1'b1;
          r_rk_oor   <= 1'b1;
          r_rk_key   <= '0;
        end else if (w_hit) begin
          r_rk_valid <= 1'b1;
          r_rk_key   <= ks_key_i;
        end else if (w_avail) begin
          r_rk_valid <= 1'b1;
          r_rk_key   <= r_buf[rk_idx_i];
        end
      end
    end
  end

  assign ks_key_o   = r_ks_key;
  assign ks_en_o    = r_ks_en;
  assign ks_round_o = r_cnt;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign rk_valid_o = r_rk_valid;
  assign rk_key_o   = r_rk_key;
  assign rk_oor_o   = r_rk_oor;

endmodule

// File: tb/tb_aes_key_sequencer.sv
// Directed bench for aes_key_sequencer with a behavioural key-schedule datapath.
module tb_aes_key_sequencer;

  localparam logic [255:0] KEY_A =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B =
    256'h00112233445566778899aabbccddeeff_f0e1d2c3b4a5968778695a4b3c2d1e0f;

  logic [127:0] tbl [0:14] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'h101112131415161718191a1b1c1d1e1f,
    128'ha573c29fa176c498a97fce93a572c09c,
    128'h1651a8cd0244beda1a5da4c10640bade,
    128'hae87dff00ff11b68a68ed5fb03fc1567,
    128'h6de1f1486fa54f9275f8eb5373b8518d,
    128'hc656827fc9a799176f294cec6cd5598b,
    128'h3de23a75524775e727bf9eb45407cf39,
    128'h0bdc905fc27b0948ad5245a4c1871c2f,
    128'h45f5a66017b2d387300d4d33640a820a,
    128'h7ccff71cbeb4fe5413e6bbf0d261a7df,
    128'hf01afafee7a82979d7a5644ab3afe640,
    128'h2541fe719bf500258813bbd55a721c0a,
    128'h4e5a6699a9f24fe07e572baacdf8cdea,
    128'h24fc79ccbf0979e9371ac23c6d68de36
  };

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [255:0] key_i;
  logic [255:0] ks_key_o;
  logic         ks_en_o;
  logic [3:0]   ks_round_o;
  logic         ks_ready_i;
  logic [127:0] ks_key_i;
  logic         rk_req_i;
  logic [3:0]   rk_idx_i;
  logic         rk_valid_o;
  logic [127:0] rk_key_o;
  logic         rk_oor_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  int n_pass  = 0;
  int n_total = 0;
  int stall_round = -1;

  aes_key_sequencer dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .key_i      (key_i),
    .ks_key_o   (ks_key_o),
    .ks_en_o    (ks_en_o),
    .ks_round_o (ks_round_o),
    .ks_ready_i (ks_ready_i),
    .ks_key_i   (ks_key_i),
    .rk_req_i   (rk_req_i),
    .rk_idx_i   (rk_idx_i),
    .rk_valid_o (rk_valid_o),
    .rk_key_o   (rk_key_o),
    .rk_oor_o   (rk_oor_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Round key the datapath produces for a given cipher key and round
  function automatic logic [127:0] rk_model(input logic [255:0] k, input logic [3:0] r);
    if (k == KEY_A) return tbl[r];
    return k[255:128] ^ k[127:0] ^ {32{r}};
  endfunction

  // Datapath: ready on the third enabled cycle of a round, key valid the cycle after
  initial begin
    int       dp_cnt;
    logic     prev_ready;
    logic     prev_en;
    logic [3:0] prev_rnd;
    dp_cnt = 0; prev_ready = 1'b0; prev_en = 1'b0; prev_rnd = 4'd0;
    ks_ready_i = 1'b0;
    ks_key_i   = '0;
    forever begin
      @(posedge clk_i); #1;
      prev_ready = ks_ready_i;
      ks_key_i = prev_ready ? rk_model(ks_key_o, ks_round_o) : ~rk_model(ks_key_o, ks_round_o);
      if (ks_en_o) begin
        if (prev_en && ks_round_o == prev_rnd) dp_cnt++;
        else dp_cnt = 1;
        ks_ready_i = (dp_cnt == 3) && (int'(ks_round_o) != stall_round);
      end else begin
        dp_cnt = 0;
        ks_ready_i = 1'b0;
      end
      prev_en  = ks_en_o;
      prev_rnd = ks_round_o;
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_start(input logic [255:0] k);
    step();
    start_i = 1'b1; key_i = k;
    step();
    start_i = 1'b0; key_i = '0;
  endtask

  task automatic do_read(input logic [3:0] idx, input int bound, output logic got,
                         output logic [127:0] key, output logic oor, output int cyc);
    rk_idx_i = idx; rk_req_i = 1'b1; cyc = 0; got = 1'b0; key = '0; oor = 1'b0;
    while (!got && cyc < bound) begin
      step(); cyc++;
      if (rk_valid_o) begin got = 1'b1; key = rk_key_o; oor = rk_oor_o; end
    end
    rk_req_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; key_i = '0; rk_req_i = 1'b0; rk_idx_i = 4'd0;
    #12;
    n_total++;
    if ({ks_en_o, busy_o, done_o, err_o, rk_valid_o, rk_oor_o, ks_round_o} !== 10'd0) begin
      $display("FAIL reset_ctrl got %b exp 0",
               {ks_en_o, busy_o, done_o, err_o, rk_valid_o, rk_oor_o, ks_round_o});
    end else n_pass++;
    n_total++;
    if ({ks_key_o, rk_key_o} !== 384'd0) $display("FAIL reset_data got %h exp 0", {ks_key_o, rk_key_o});
    else n_pass++;
    @(negedge clk_i) rst_n = 1'b1;
    step();
  endtask

  task automatic test_expand();
    int n; int rounds_seen; int first_v; logic prev_en; logic [127:0] vkey;
    rk_idx_i = 4'd14; rk_req_i = 1'b1;
    pulse_start(KEY_A);
    n_total++;
    if (ks_key_o !== KEY_A) $display("FAIL ks_key_latch got %h exp %h", ks_key_o, KEY_A);
    else n_pass++;
    n = 0; rounds_seen = 0; first_v = -1; prev_en = 1'b0; vkey = '0;
    while (!done_o && n < 200) begin
      if (ks_en_o && !prev_en) begin
        n_total++;
        if (ks_round_o !== 4'(rounds_seen) || busy_o !== 1'b1)
          $display("FAIL round_step got %0d/%b exp %0d/1", ks_round_o, busy_o, rounds_seen);
        else n_pass++;
        rounds_seen++;
      end
      prev_en = ks_en_o;
      step(); n++;
      if (rk_valid_o && first_v < 0) begin first_v = n; vkey = rk_key_o; end
    end
    rk_req_i = 1'b0;
    n_total++;
    if (n !== 60 || rounds_seen !== 15) $display("FAIL expand_latency got %0d/%0d exp 60/15", n, rounds_seen);
    else n_pass++;
    n_total++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) $display("FAIL done_status got busy=%b err=%b exp 0 0", busy_o, err_o);
    else n_pass++;
    n_total++;
    if (first_v !== 60 || vkey !== tbl[14])
      $display("FAIL bypass_read14 got cyc=%0d key=%h exp cyc=60 key=%h", first_v, vkey, tbl[14]);
    else n_pass++;
    step();
  endtask

  task automatic test_reads();
    logic g; logic [127:0] k; logic o; int c;
    for (int i = 0; i < 15; i += 7) begin
      do_read(4'(i), 8, g, k, o, c);
      n_total++;
      if (!g || k !== tbl[i] || o !== 1'b0 || c !== 1)
        $display("FAIL read_idx%0d got v=%b key=%h oor=%b cyc=%0d exp key=%h", i, g, k, o, c, tbl[i]);
      else n_pass++;
    end
    do_read(4'd1, 8, g, k, o, c);
    n_total++;
    if (!g || k !== tbl[1]) $display("FAIL read_idx1 got %h exp %h", k, tbl[1]);
    else n_pass++;
    n_total++;
    if (rk_valid_o !== 1'b0 || rk_key_o !== tbl[1])
      $display("FAIL key_hold got v=%b key=%h exp 0 %h", rk_valid_o, rk_key_o, tbl[1]);
    else n_pass++;
    do_read(4'd15, 8, g, k, o, c);
    n_total++;
    if (!g || o !== 1'b1 || k !== 128'd0 || c !== 1)
      $display("FAIL read_oor got v=%b oor=%b key=%h cyc=%0d exp 1 1 0 1", g, o, k, c);
    else n_pass++;
    n_total++;
    if (rk_oor_o !== 1'b0) $display("FAIL oor_clear got %b exp 0", rk_oor_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    pat = '0;
    rk_idx_i = 4'd2; rk_req_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      pat = {pat[4:0], rk_valid_o};
    end
    n_total++;
    if (pat !== 6'b101010 || rk_key_o !== tbl[2])
      $display("FAIL held_req_pattern got %b key=%h exp 101010 %h", pat, rk_key_o, tbl[2]);
    else n_pass++;
    rk_req_i = 1'b0;
    step();
  endtask

  task automatic test_error();
    int n; logic g; logic [127:0] k; logic o; int c;
    stall_round = 5;
    pulse_start(KEY_A);
    n = 0;
    while (!err_o && n < 200) begin step(); n++; end
    n_total++;
    if (n !== 52) $display("FAIL timeout_latency got %0d exp 52", n);
    else n_pass++;
    n_total++;
    if ({err_o, ks_en_o, busy_o, done_o} !== 4'b1000)
      $display("FAIL error_status got %b exp 1000", {err_o, ks_en_o, busy_o, done_o});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      do_read(4'(i), 8, g, k, o, c);
      n_total++;
      if (!g || k !== tbl[i]) $display("FAIL err_read_idx%0d got v=%b key=%h exp %h", i, g, k, tbl[i]);
      else n_pass++;
    end
    do_read(4'd5, 8, g, k, o, c);
    n_total++;
    if (g !== 1'b0) $display("FAIL err_read_idx5_stall got v=%b exp 0", g);
    else n_pass++;
    stall_round = -1;
  endtask

  task automatic test_restart();
    int n; logic g; logic [127:0] k; logic o; int c;
    pulse_start(KEY_A);
    n_total++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL start_clears_err got err=%b busy=%b exp 0 1", err_o, busy_o);
    else n_pass++;
    n = 0;
    while (!(ks_en_o && ks_round_o == 4'd7) && n < 200) begin step(); n++; end
    pulse_start(KEY_B);
    n_total++;
    if (ks_round_o !== 4'd0 || ks_en_o !== 1'b1 || ks_key_o !== KEY_B)
      $display("FAIL restart_issue got rnd=%0d en=%b key=%h exp 0 1 %h", ks_round_o, ks_en_o, ks_key_o, KEY_B);
    else n_pass++;
    do_read(4'd3, 100, g, k, o, c);
    n_total++;
    if (!g || c !== 16 || k !== rk_model(KEY_B, 4'd3))
      $display("FAIL restart_read3 got v=%b cyc=%0d key=%h exp cyc=16 key=%h", g, c, k, rk_model(KEY_B, 4'd3));
    else n_pass++;
    n = 0;
    while (!done_o && n < 200) begin step(); n++; end
    do_read(4'd14, 8, g, k, o, c);
    n_total++;
    if (!g || k !== rk_model(KEY_B, 4'd14))
      $display("FAIL restart_read14 got v=%b key=%h exp %h", g, k, rk_model(KEY_B, 4'd14));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n; logic g; logic [127:0] k; logic o; int c;
    pulse_start(KEY_A);
    n = 0;
    while (!(ks_round_o == 4'd9 && busy_o && !ks_en_o) && n < 200) begin step(); n++; end
    n_total++;
    if (n >= 200) $display("FAIL reach_capture9 got timeout exp capture");
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({ks_en_o, busy_o, done_o, err_o, rk_valid_o, rk_oor_o, ks_round_o} !== 10'd0 || ks_key_o !== 256'd0)
      $display("FAIL async_reset got %b key=%h exp 0",
               {ks_en_o, busy_o, done_o, err_o, rk_valid_o, rk_oor_o, ks_round_o}, ks_key_o);
    else n_pass++;
    @(negedge clk_i) rst_n = 1'b1;
    step();
    n_total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL post_reset_status got done=%b busy=%b exp 0 0", done_o, busy_o);
    else n_pass++;
    do_read(4'd0, 8, g, k, o, c);
    n_total++;
    if (g !== 1'b0) $display("FAIL post_reset_read0 got v=%b exp 0", g);
    else n_pass++;
    do_read(4'd14, 8, g, k, o, c);
    n_total++;
    if (g !== 1'b0) $display("FAIL post_reset_read14 got v=%b exp 0", g);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_expand();
    test_reads();
    test_back_to_back();
    test_error();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
